// File: rtl/name_issue_assembler.sv
// name_issue_assembler
// Collects name component words from a one-word-per-cycle valid/ready stream
// into one of two ping-pong buffers and presents the oldest complete name,
// zero padded, as a parallel vector to the FIB lookup tree.
// Optional feature macro: NAME_TAG_EN adds name_tag_out, a per-issue sequence tag.
module name_issue_assembler #(
   parameter int WORD_SIZE       = 64,
   parameter int MAX_NAME_LENGTH = 16,
   parameter int LEN_W           = $clog2(MAX_NAME_LENGTH + 1),
   parameter int TAG_W           = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] word_in,
   input  logic                 word_valid_in,
   input  logic                 word_last_in,
   output logic                 word_ready_out,
   output logic [WORD_SIZE-1:0] name_out [MAX_NAME_LENGTH],
   output logic [LEN_W-1:0]     name_len_out,
   output logic                 name_valid_out,
   input  logic                 name_ready_in,
`ifdef NAME_TAG_EN
   output logic [TAG_W-1:0]     name_tag_out,
`endif
   output logic                 overflow_out
);

   localparam int IDX_W = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} fill_state_e;

   fill_state_e          state_q, state_d;
   logic [LEN_W-1:0]     count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic                 wr_sel_q;   // buffer currently being filled
   logic                 rd_sel_q;   // oldest buffer, the one presented on name_out
   logic [1:0]           full_q;
   logic [LEN_W-1:0]     blen_q [2];
   logic [WORD_SIZE-1:0] buf_q  [2][MAX_NAME_LENGTH];

   logic wr_en, commit, discard;
   logic word_fire, name_fire;

   // DROP swallows words regardless of buffer state, so it never stalls the source.
   assign word_ready_out = !rst && (!full_q[wr_sel_q] || (state_q == S_DROP));
   assign word_fire      = word_valid_in && word_ready_out;
   assign name_fire      = name_valid_out && name_ready_in;
   assign overflow_out   = ovf_q;

   // Fill state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Fill next-state: write, complete, or drop an oversize name.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      wr_en   = 1'b0;
      commit  = 1'b0;
      discard = 1'b0;
      if (word_fire) begin
         case (state_q)
            S_IDLE, S_FILL: begin
               if (count_q == LEN_W'(MAX_NAME_LENGTH)) begin
                  ovf_d   = 1'b1;
                  discard = 1'b1;
                  count_d = '0;
                  state_d = word_last_in ? S_IDLE : S_DROP;
               end else begin
                  wr_en = 1'b1;
                  if (word_last_in) begin
                     commit  = 1'b1;
                     count_d = '0;
                     state_d = S_IDLE;
                  end else begin
                     count_d = count_q + LEN_W'(1);
                     state_d = S_FILL;
                  end
               end
            end
            S_DROP: begin
               if (word_last_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Ping-pong buffers. Writes only go to an empty buffer and issue only frees
   // a full one, so fill and issue in the same edge never touch the same buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         full_q   <= '0;
         for (int b = 0; b < 2; b++) begin
            blen_q[b] <= '0;
            for (int i = 0; i < MAX_NAME_LENGTH; i++) buf_q[b][i] <= '0;
         end
      end else begin
         if (name_fire) begin
            full_q[rd_sel_q] <= 1'b0;
            blen_q[rd_sel_q] <= '0;
            rd_sel_q         <= ~rd_sel_q;
            for (int i = 0; i < MAX_NAME_LENGTH; i++) buf_q[rd_sel_q][i] <= '0;
         end
         if (wr_en) buf_q[wr_sel_q][count_q[IDX_W-1:0]] <= word_in;
         if (commit) begin
            full_q[wr_sel_q] <= 1'b1;
            blen_q[wr_sel_q] <= count_q + LEN_W'(1);
            wr_sel_q         <= ~wr_sel_q;
         end
         if (discard) begin
            for (int i = 0; i < MAX_NAME_LENGTH; i++) buf_q[wr_sel_q][i] <= '0;
         end
      end
   end

   // Present the oldest buffer; a partially filled buffer is masked to zero.
   always_comb begin
      name_valid_out = full_q[rd_sel_q];
      name_len_out   = full_q[rd_sel_q] ? blen_q[rd_sel_q] : '0;
      for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
         name_out[i] = full_q[rd_sel_q] ? buf_q[rd_sel_q][i] : '0;
      end
   end

`ifdef NAME_TAG_EN
   logic [TAG_W-1:0] tag_q;
   assign name_tag_out = tag_q;

   // Issue tag advances on every name transfer and wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tag_q <= '0;
      else if (name_fire) tag_q <= tag_q + TAG_W'(1);
   end
`endif

endmodule

// File: tb/tb_name_issue_assembler.sv
// Scoreboard bench for name_issue_assembler: expected names are queued when
// their last word is accepted and compared when the DUT transfers a name.
module tb_name_issue_assembler;
   localparam int W  = 64;
   localparam int M  = 16;
   localparam int LW = 5;
   localparam int TW = 8;

   typedef struct packed {
      logic [LW-1:0]  len;
      logic [M*W-1:0] w;
   } name_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  word_in;
   logic          word_valid_in;
   logic          word_last_in;
   logic          word_ready_out;
   logic [W-1:0]  name_out [M];
   logic [LW-1:0] name_len_out;
   logic          name_valid_out;
   logic          name_ready_in;
   logic          overflow_out;
`ifdef NAME_TAG_EN
   logic [TW-1:0] name_tag_out;
   logic [TW-1:0] exp_tag;
`endif

   name_issue_assembler #(.WORD_SIZE(W), .MAX_NAME_LENGTH(M), .LEN_W(LW), .TAG_W(TW)) dut (
      .clk            (clk),
      .rst            (rst),
      .word_in        (word_in),
      .word_valid_in  (word_valid_in),
      .word_last_in   (word_last_in),
      .word_ready_out (word_ready_out),
      .name_out       (name_out),
      .name_len_out   (name_len_out),
      .name_valid_out (name_valid_out),
      .name_ready_in  (name_ready_in),
`ifdef NAME_TAG_EN
      .name_tag_out   (name_tag_out),
`endif
      .overflow_out   (overflow_out)
   );

   always #5 clk = ~clk;

   int    n_assert = 0;
   int    n_fail   = 0;
   int    ovf_cnt  = 0;
   int    issued   = 0;
   name_t sb [$];
   name_t mon_e;
   name_t e1;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Transfer monitor, sampled on the falling edge before the transfer edge.
   always @(negedge clk) begin
      if (!rst && overflow_out) ovf_cnt++;
      if (!rst && name_valid_out && name_ready_in) begin
         if (sb.size() == 0) begin
            check("unexpected_name", W'(1), W'(0));
         end else begin
            mon_e = sb.pop_front();
            check("name_len", W'(name_len_out), W'(mon_e.len));
            for (int i = 0; i < M; i++) check("name_word", name_out[i], mon_e.w[i*W +: W]);
         end
`ifdef NAME_TAG_EN
         check("name_tag", W'(name_tag_out), W'(exp_tag));
         exp_tag = exp_tag + TW'(1);
`endif
         issued++;
      end
   end

   task automatic send_word(input logic [W-1:0] w, input logic last);
      int t = 0;
      word_in       = w;
      word_last_in  = last;
      word_valid_in = 1'b1;
      while (1) begin
         @(negedge clk);
         if (word_ready_out) break;
         t++;
         if (t > 300) begin
            check("word_accept_timeout", W'(0), W'(1));
            break;
         end
      end
      @(posedge clk);
      #1;
      word_valid_in = 1'b0;
      word_last_in  = 1'b0;
   endtask

   task automatic send_name(input int n);
      name_t       e;
      logic [W-1:0] w;
      e     = '0;
      e.len = LW'(n);
      for (int i = 0; i < n; i++) begin
         w = {$urandom(), $urandom()};
         if (i < M) e.w[i*W +: W] = w;
         send_word(w, i == n - 1);
      end
      if (n <= M) sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (sb.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check(tag, W'(sb.size()), W'(0));
   endtask

   initial begin
      bit done;
      rst = 1'b1; word_in = '0; word_valid_in = 1'b0; word_last_in = 1'b0; name_ready_in = 1'b0;
`ifdef NAME_TAG_EN
      exp_tag = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_word_ready", W'(word_ready_out), W'(0));
      check("rst_valid",      W'(name_valid_out), W'(0));
      check("rst_len",        W'(name_len_out),   W'(0));
      check("rst_overflow",   W'(overflow_out),   W'(0));
      check("rst_word0",      name_out[0],        W'(0));
`ifdef NAME_TAG_EN
      check("rst_tag",        W'(name_tag_out),   W'(0));
`endif
      rst = 1'b0;
      #1;
      check("post_rst_ready", W'(word_ready_out), W'(1));

      // 3-word name A,B,C, valid one cycle after C
      name_ready_in = 1'b1;
      e1 = '0; e1.len = LW'(3);
      e1.w[0 +: W] = 64'hAAAA_0000_0000_000A;
      e1.w[W +: W] = 64'hBBBB_0000_0000_000B;
      e1.w[2*W +: W] = 64'hCCCC_0000_0000_000C;
      send_word(64'hAAAA_0000_0000_000A, 1'b0);
      send_word(64'hBBBB_0000_0000_000B, 1'b0);
      check("t1_valid_early", W'(name_valid_out), W'(0));
      send_word(64'hCCCC_0000_0000_000C, 1'b1);
      sb.push_back(e1);
      check("t1_valid_lat1", W'(name_valid_out), W'(1));
      check("t1_len",        W'(name_len_out),   W'(3));
      drain("t1_drain");
      check("t1_valid_after", W'(name_valid_out), W'(0));

      // maximum-length name, then oversize name, then a short name
      ovf_cnt = 0;
      send_name(16);
      drain("t2_16_drain");
      check("t2_no_overflow", W'(ovf_cnt), W'(0));
      issued = 0;
      send_name(17);
      repeat (3) @(posedge clk);
      #1;
      check("t2_overflow_once", W'(ovf_cnt), W'(1));
      check("t2_no_issue",      W'(issued),  W'(0));
      send_name(2);
      drain("t2_short_drain");
      check("t2_issue_count", W'(issued), W'(1));

      // back-pressure: two names fill both buffers, third waits
      name_ready_in = 1'b0;
      issued = 0;
      send_name(1);
      send_name(1);
      check("t3_ready_low", W'(word_ready_out), W'(0));
      repeat (4) @(posedge clk);
      #1;
      check("t3_hold_valid", W'(name_valid_out), W'(1));
      check("t3_hold_word",  name_out[0], sb[0].w[W-1:0]);
      check("t3_hold_len",   W'(name_len_out), W'(1));
      fork
         send_name(1);
         begin repeat (4) @(posedge clk); #1; name_ready_in = 1'b1; end
      join
      drain("t3_drain");
      check("t3_issue_count", W'(issued), W'(3));

      // asynchronous reset mid-name with a held name
      name_ready_in = 1'b0;
      send_name(1);
      for (int i = 0; i < 5; i++) send_word({$urandom(), $urandom()}, 1'b0);
      check("t4_pre_valid", W'(name_valid_out), W'(1));
      #3;
      rst = 1'b1;
      #1;
      sb.delete();
`ifdef NAME_TAG_EN
      exp_tag = '0;
      check("t4_rst_tag", W'(name_tag_out), W'(0));
`endif
      check("t4_rst_valid", W'(name_valid_out), W'(0));
      check("t4_rst_len",   W'(name_len_out),   W'(0));
      check("t4_rst_word0", name_out[0],        W'(0));
      check("t4_rst_ready", W'(word_ready_out), W'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      name_ready_in = 1'b1;
      issued = 0;
      send_name(1);
      drain("t4_drain");
      check("t4_issue_count", W'(issued), W'(1));

      // last word accepted in the same edge as the other buffer issues
      name_ready_in = 1'b0;
      issued = 0;
      send_name(1);
      e1 = '0; e1.len = LW'(2);
      e1.w[0 +: W] = 64'h5151_5151_0000_0001;
      e1.w[W +: W] = 64'h5252_5252_0000_0002;
      send_word(64'h5151_5151_0000_0001, 1'b0);
      word_in = 64'h5252_5252_0000_0002; word_last_in = 1'b1; word_valid_in = 1'b1;
      name_ready_in = 1'b1;
      check("t5_both_ready", W'(word_ready_out), W'(1));
      sb.push_back(e1);
      @(posedge clk);
      #1;
      word_valid_in = 1'b0; word_last_in = 1'b0;
      check("t5_second_valid", W'(name_valid_out), W'(1));
      check("t5_second_len",   W'(name_len_out),   W'(2));
      drain("t5_drain");
      check("t5_issue_count", W'(issued), W'(2));

      // random lengths with random back-pressure
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 20; k++) send_name($urandom_range(1, M));
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               name_ready_in = 1'($urandom_range(0, 1));
            end
         end
      join
      name_ready_in = 1'b1;
      drain("rand_drain");

`ifdef NAME_TAG_EN
      // tag wrap across 257 issues
      for (int k = 0; k < 257; k++) send_name(1);
      drain("t6_drain");
`endif

      check("final_no_overflow_left", W'(overflow_out), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
